imem_boot_loader: RTL

//  Upstream of SingleCycleCPU: receives a byte stream and writes it word by word into instruction memory.

---
 rtl/imem_boot_loader.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: streams a little-endian word-count-prefixed program image into instruction memory
// and holds the CPU in reset until the image is complete; re-arms when the CPU halts.
//
// Parameter:
//   ADDR_WIDTH     instruction-memory word-address width (capacity 2**ADDR_WIDTH words)
// Optional feature macro:
//   IMEM_LOADER_CKSUM_EN   adds a trailing 32-bit checksum word (wrapping sum of the payload)
// Ports:
//   clk_i          system clock, rising edge
//   reset_i        synchronous active-high reset
//   in_valid_i     byte-stream valid
//   in_data_i      byte-stream data
//   in_ready_o     byte accepted when in_valid_i && in_ready_o
//   imem_we_o      one-cycle instruction-memory write strobe
//   imem_addr_o    word address being written
//   imem_wdata_o   assembled word being written
//   cpu_reset_o    CPU reset, low only while running
//   halt_i         CPU halt flag, re-arms the loader
//   load_done_o    high while the CPU runs
//   load_err_o     sticky error, cleared only by reset
module imem_boot_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  in_valid_i,
    input  logic [7:0]            in_data_i,
    output logic                  in_ready_o,
    output logic                  imem_we_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    output logic [31:0]           imem_wdata_o,
    output logic                  cpu_reset_o,
    input  logic                  halt_i,
    output logic                  load_done_o,
    output logic                  load_err_o
);
`ifdef IMEM_LOADER_CKSUM_EN
    typedef enum logic [2:0] {HDR, LOAD, RUN, ERR, CKSUM} state_e;
`else
    typedef enum logic [2:0] {HDR, LOAD, RUN, ERR} state_e;
`endif
    localparam logic [32:0] CAP = 33'(1) << ADDR_WIDTH;
    state_e                state_q;
    logic [1:0]            cnt_q;
    logic [23:0]           word_q;
    logic [ADDR_WIDTH:0]   n_q;
    logic [ADDR_WIDTH:0]   idx_q;
    logic                  in_ready_q;
    logic                  imem_we_q;
    logic [ADDR_WIDTH-1:0] imem_addr_q;
    logic [31:0]           imem_wdata_q;
    logic                  cpu_reset_q;
    logic                  load_done_q;
    logic                  load_err_q;
`ifdef IMEM_LOADER_CKSUM_EN
    logic [31:0]           sum_q;
`endif
    logic                  accept;
    logic                  last_byte;
    logic [31:0]           word_d;
    logic [ADDR_WIDTH:0]   idx_d;
    assign accept    = in_valid_i && in_ready_q;
    assign last_byte = accept && cnt_q == 2'd3;
    // Earlier bytes are shifted down so the fourth byte completes the LE word at the top.
    assign word_d    = {in_data_i, word_q};
    assign idx_d     = idx_q + (ADDR_WIDTH+1)'(1);
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= HDR;
            cnt_q        <= '0;
            word_q       <= '0;
            n_q          <= '0;
            idx_q        <= '0;
            in_ready_q   <= 1'b1;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_reset_q  <= 1'b1;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            imem_we_q   <= 1'b0;
            // Accepting states re-open after a write strobe; transitions below override.
            in_ready_q  <= state_q != RUN && state_q != ERR;
            // Registered, so the CPU leaves reset one cycle after RUN is entered.
            cpu_reset_q <= !(state_q == RUN && !halt_i);
            if (accept) begin
                cnt_q  <= cnt_q + 2'd1;
                word_q <= {in_data_i, word_q[23:8]};
            end
            case (state_q)
                HDR: begin
`ifdef IMEM_LOADER_CKSUM_EN
                    sum_q <= '0;
`endif
                    if (last_byte) begin
                        if ({1'b0, word_d} > CAP) begin
                            state_q    <= ERR;
                            in_ready_q <= 1'b0;
                            load_err_q <= 1'b1;
                        end else if (word_d == '0) begin
`ifdef IMEM_LOADER_CKSUM_EN
                            state_q     <= CKSUM;
`else
                            state_q     <= RUN;
                            in_ready_q  <= 1'b0;
                            load_done_q <= 1'b1;
`endif
                        end else begin
                            state_q <= LOAD;
                            n_q     <= word_d[ADDR_WIDTH:0];
                            idx_q   <= '0;
                        end
                    end
                end
                LOAD: begin
                    if (last_byte) begin
                        imem_we_q    <= 1'b1;
                        imem_addr_q  <= idx_q[ADDR_WIDTH-1:0];
                        imem_wdata_q <= word_d;
                        idx_q        <= idx_d;
                        in_ready_q   <= 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
                        sum_q        <= sum_q + word_d;
                        if (idx_d == n_q) state_q <= CKSUM;
`else
                        if (idx_d == n_q) begin
                            state_q     <= RUN;
                            load_done_q <= 1'b1;
                        end
`endif
                    end
                end
`ifdef IMEM_LOADER_CKSUM_EN
                CKSUM: begin
                    if (last_byte) begin
                        in_ready_q <= 1'b0;
                        if (word_d == sum_q) begin
                            state_q     <= RUN;
                            load_done_q <= 1'b1;
                        end else begin
                            state_q    <= ERR;
                            load_err_q <= 1'b1;
                        end
                    end
                end
`endif
                RUN: begin
                    if (halt_i) begin
                        state_q     <= HDR;
                        in_ready_q  <= 1'b1;
                        load_done_q <= 1'b0;
                        cnt_q       <= '0;
                        idx_q       <= '0;
                    end
                end
                ERR: ;
                default: state_q <= ERR;
            endcase
        end
    end
    assign in_ready_o   = in_ready_q;
    assign imem_we_o    = imem_we_q;
    assign imem_addr_o  = imem_addr_q;
    assign imem_wdata_o = imem_wdata_q;
    assign cpu_reset_o  = cpu_reset_q;
    assign load_done_o  = load_done_q;
    assign load_err_o   = load_err_q;
endmodule
